// File: rtl/audio_sram_arbiter.sv
// audio_sram_arbiter
//   Shares the single external audio SRAM between the recorder (writes) and the
//   DSP player (reads). One requester is granted at a time; ties alternate so
//   neither side starves. Each access is sequenced on the SRAM strobes with a
//   full cycle of address/data setup and hold around the write strobe. The
//   highest written address is tracked, so reads past the end of the recording
//   return zero with an EOF flag instead of stale memory.
//
// Ports
//   i_clk, i_rst_n           bclk domain clock, async active-low reset
//   i_clear                  pulse: forget recorded length (new session)
//   i_rec_req/addr/data      recorder write request (level, held until ack)
//   o_rec_ack                pulse: write committed
//   i_play_req/addr          player read request (level, held until ack)
//   o_play_data              read sample, held until the next read ack
//   o_play_ack, o_play_eof   pulse: data updated / address beyond recording
//   o_sram_*                 SRAM address, write data, strobes, DQ enable
//   i_sram_rdata             DQ pins as read
//   o_last_addr, o_has_data  recorded extent since clear/reset
module audio_sram_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clear,
  input  logic                     i_rec_req,
  input  logic [ADDR_W-1:0]        i_rec_addr,
  input  logic signed [DATA_W-1:0] i_rec_data,
  output logic                     o_rec_ack,
  input  logic                     i_play_req,
  input  logic [ADDR_W-1:0]        i_play_addr,
  output logic signed [DATA_W-1:0] o_play_data,
  output logic                     o_play_ack,
  output logic                     o_play_eof,
  output logic [ADDR_W-1:0]        o_sram_addr,
  output logic [DATA_W-1:0]        o_sram_wdata,
  input  logic [DATA_W-1:0]        i_sram_rdata,
  output logic                     o_sram_dq_oe,
  output logic                     o_sram_ce_n,
  output logic                     o_sram_we_n,
  output logic                     o_sram_oe_n,
  output logic [ADDR_W-1:0]        o_last_addr,
  output logic                     o_has_data
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_STROBE = 3'd2,
    W_HOLD   = 3'd3,
    R_STROBE = 3'd4,
    R_LATCH  = 3'd5
  } state_t;

  localparam logic GRANT_PLAY = 1'b0;
  localparam logic GRANT_REC  = 1'b1;

  state_t r_state;
  logic   r_last_grant;

  logic w_rec_win;
  logic w_play_beyond;

  // Recorder wins when alone, or on a tie when the player was served last.
  assign w_rec_win     = i_rec_req && (!i_play_req || (r_last_grant == GRANT_PLAY));
  assign w_play_beyond = !o_has_data || (i_play_addr > o_last_addr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_PLAY;
      o_sram_ce_n  <= 1'b1;
      o_sram_we_n  <= 1'b1;
      o_sram_oe_n  <= 1'b1;
      o_sram_dq_oe <= 1'b0;
      o_sram_addr  <= '0;
      o_sram_wdata <= '0;
      o_play_data  <= '0;
      o_rec_ack    <= 1'b0;
      o_play_ack   <= 1'b0;
      o_play_eof   <= 1'b0;
    end else begin
      o_rec_ack  <= 1'b0;
      o_play_ack <= 1'b0;
      o_play_eof <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rec_win) begin
            r_last_grant <= GRANT_REC;
            r_state      <= W_SETUP;
            o_sram_addr  <= i_rec_addr;
            o_sram_wdata <= i_rec_data;
            o_sram_ce_n  <= 1'b0;
            o_sram_dq_oe <= 1'b1;
          end else if (i_play_req) begin
            r_last_grant <= GRANT_PLAY;
            if (w_play_beyond) begin
              // No SRAM cycle: answer with silence and flag end of recording.
              // R_LATCH supplies the mandatory idle gap before the next grant.
              r_state     <= R_LATCH;
              o_play_data <= '0;
              o_play_ack  <= 1'b1;
              o_play_eof  <= 1'b1;
            end else begin
              r_state     <= R_STROBE;
              o_sram_addr <= i_play_addr;
              o_sram_ce_n <= 1'b0;
              o_sram_oe_n <= 1'b0;
            end
          end
        end
        W_SETUP: begin
          r_state     <= W_STROBE;
          o_sram_we_n <= 1'b0;
        end
        W_STROBE: begin
          r_state     <= W_HOLD;
          o_sram_we_n <= 1'b1;
          o_rec_ack   <= 1'b1;
        end
        W_HOLD: begin
          r_state      <= IDLE;
          o_sram_ce_n  <= 1'b1;
          o_sram_dq_oe <= 1'b0;
        end
        R_STROBE: begin
          r_state     <= R_LATCH;
          o_play_data <= $signed(i_sram_rdata);
          o_play_ack  <= 1'b1;
        end
        R_LATCH: begin
          r_state     <= IDLE;
          o_sram_ce_n <= 1'b1;
          o_sram_oe_n <= 1'b1;
        end
        default: begin
          r_state      <= IDLE;
          o_sram_ce_n  <= 1'b1;
          o_sram_we_n  <= 1'b1;
          o_sram_oe_n  <= 1'b1;
          o_sram_dq_oe <= 1'b0;
        end
      endcase
    end
  end

  // Recorded extent. The write address is still on o_sram_addr during W_HOLD,
  // so it is taken from there. A clear in the ack cycle discards that write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_last_addr <= '0;
      o_has_data  <= 1'b0;
    end else if (i_clear) begin
      o_last_addr <= '0;
      o_has_data  <= 1'b0;
    end else if (r_state == W_HOLD) begin
      if (!o_has_data || (o_sram_addr > o_last_addr)) begin
        o_last_addr <= o_sram_addr;
      end
      o_has_data <= 1'b1;
    end
  end

endmodule

// File: tb/tb_audio_sram_arbiter.sv
// tb_audio_sram_arbiter
//   Scoreboarded bench for audio_sram_arbiter. Stimulus tasks push the expected
//   response of each request into a queue; a monitor pops and compares on every
//   ack. Expected data comes from a reference memory plus recorded-extent model.
module tb_audio_sram_arbiter;
  localparam int AW = 20;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          rec_req = 1'b0;
  logic [AW-1:0] rec_addr = '0;
  logic [DW-1:0] rec_data = '0;
  logic          play_req = 1'b0;
  logic [AW-1:0] play_addr = '0;
  logic [DW-1:0] sram_rdata = '0;

  logic          rec_ack, play_ack, play_eof;
  logic [DW-1:0] play_data;
  logic [AW-1:0] sram_addr, last_addr;
  logic [DW-1:0] sram_wdata;
  logic          dq_oe, ce_n, we_n, oe_n, has_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  audio_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear),
    .i_rec_req(rec_req), .i_rec_addr(rec_addr), .i_rec_data(rec_data), .o_rec_ack(rec_ack),
    .i_play_req(play_req), .i_play_addr(play_addr), .o_play_data(play_data),
    .o_play_ack(play_ack), .o_play_eof(play_eof),
    .o_sram_addr(sram_addr), .o_sram_wdata(sram_wdata), .i_sram_rdata(sram_rdata),
    .o_sram_dq_oe(dq_oe), .o_sram_ce_n(ce_n), .o_sram_we_n(we_n), .o_sram_oe_n(oe_n),
    .o_last_addr(last_addr), .o_has_data(has_data)
  );

  typedef struct packed {
    logic          is_rd;
    logic [DW-1:0] data;
    logic          eof;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;

  // Reference model: memory contents and recorded extent.
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] sram_mem [logic [AW-1:0]];
  logic [AW-1:0] m_last = '0;
  logic          m_has = 1'b0;

  function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return fill(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    failures++;
    $display("FAIL %s", name);
  endtask

  task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.is_rd = 1'b0; e.data = d; e.eof = 1'b0;
    sb.push_back(e);
    ref_mem[a] = d;
    if (!m_has || a > m_last) m_last = a;
    m_has = 1'b1;
  endtask

  task automatic push_read(input logic [AW-1:0] a, output exp_t e);
    e.is_rd = 1'b1;
    e.eof   = !m_has || (a > m_last);
    e.data  = e.eof ? '0 : ref_rd(a);
    sb.push_back(e);
  endtask

  // SRAM behaviour on the pins.
  task automatic sram_step();
    if (!ce_n && !we_n) begin
      check("sram_we_with_dq_oe", 64'(dq_oe), 64'(1));
      sram_mem[sram_addr] = sram_wdata;
    end
    if (!ce_n && !oe_n)
      sram_rdata = sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : fill(sram_addr);
    else
      sram_rdata = 16'hBEEF;
  endtask

  task automatic monitor_step();
    if (!rst_n) return;
    if (play_eof && !play_ack) note_fail("eof_without_ack");
    if (rec_ack || play_ack) begin
      check("single_ack", 64'(rec_ack & play_ack), 64'(0));
      if (sb.size() == 0) begin
        note_fail("unexpected_ack");
      end else begin
        e_mon = sb.pop_front();
        check("ack_kind", 64'(play_ack), 64'(e_mon.is_rd));
        if (e_mon.is_rd) begin
          check("rd_data", 64'(play_data), 64'(e_mon.data));
          check("rd_eof", 64'(play_eof), 64'(e_mon.eof));
        end
      end
    end
  endtask

  always @(negedge clk) sram_step();
  always @(negedge clk) monitor_step();

  a_no_contention: assert property (@(negedge clk) !(dq_oe && !oe_n))
    else note_fail("bus_contention dq_oe=1 with oe_n=0");

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit clear_at_ack);
    int ack_k = -1;
    int we_mask = 0;
    bit hold_ok = 1'b1;
    push_write(a, d);
    @(posedge clk); #1;
    rec_addr = a; rec_data = d; rec_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (!we_n) we_mask |= (1 << k);
      if (k >= 1 && (sram_addr !== a || sram_wdata !== d || dq_oe !== 1'b1 || ce_n !== 1'b0))
        hold_ok = 1'b0;
      if (rec_ack) begin ack_k = k; break; end
    end
    check("wr_ack_latency", 64'(ack_k), 64'(3));
    check("wr_we_pulse", 64'(we_mask), 64'(4));
    check("wr_bus_hold", 64'(hold_ok), 64'(1));
    if (clear_at_ack) clear = 1'b1;
    @(posedge clk); #1;
    rec_req = 1'b0;
    clear = 1'b0;
    if (clear_at_ack) begin m_has = 1'b0; m_last = '0; end
    @(negedge clk);
    check("wr_last_addr", 64'(last_addr), 64'(m_last));
    check("wr_has_data", 64'(has_data), 64'(m_has));
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    exp_t e;
    int ack_k = -1;
    int oe_mask = 0;
    push_read(a, e);
    @(posedge clk); #1;
    play_addr = a; play_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (!oe_n) oe_mask |= (1 << k);
      if (play_ack) begin ack_k = k; break; end
    end
    check("rd_ack_latency", 64'(ack_k), e.eof ? 64'(1) : 64'(2));
    check("rd_oe_window", 64'(oe_mask), e.eof ? 64'(0) : 64'(6));
    @(posedge clk); #1;
    play_req = 1'b0;
    @(negedge clk);
    check("rd_data_hold", 64'(play_data), 64'(e.data));
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    m_has = 1'b0; m_last = '0;
    @(negedge clk);
    check("clear_has_data", 64'(has_data), 64'(0));
    check("clear_last_addr", 64'(last_addr), 64'(0));
  endtask

  // Both requesters held continuously; grants must alternate, recorder first.
  task automatic contention(input int n);
    logic [DW-1:0] d [8];
    logic [AW-1:0] a = 20'h00200;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      d[i] = 16'($urandom);
      push_write(a, d[i]);
      push_read(a, e);
    end
    @(posedge clk); #1;
    rec_addr = a; rec_data = d[0]; rec_req = 1'b1;
    play_addr = a; play_req = 1'b1;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          int t = 0;
          do begin @(negedge clk); t++; end while (!rec_ack && t < 40);
          if (!rec_ack) note_fail("contention_rec_timeout");
          @(posedge clk); #1;
          if (i < n - 1) rec_data = d[i+1];
          else rec_req = 1'b0;
        end
      end
      begin
        for (int i = 0; i < n; i++) begin
          int t = 0;
          do begin @(negedge clk); t++; end while (!play_ack && t < 40);
          if (!play_ack) note_fail("contention_play_timeout");
          @(posedge clk); #1;
          if (i == n - 1) play_req = 1'b0;
        end
      end
    join
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit any_ack;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ce_n", 64'(ce_n), 64'(1));
    check("rst_we_n", 64'(we_n), 64'(1));
    check("rst_oe_n", 64'(oe_n), 64'(1));
    check("rst_dq_oe", 64'(dq_oe), 64'(0));
    check("rst_has_data", 64'(has_data), 64'(0));
    check("rst_last_addr", 64'(last_addr), 64'(0));
    check("rst_play_data", 64'(play_data), 64'(0));
    check("rst_sram_addr", 64'(sram_addr), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Empty recording: read is EOF; then single write and read-backs
    do_read(20'h00000);
    do_write(20'h00010, 16'h8001, 1'b0);
    do_read(20'h00010);
    do_read(20'h00011);

    // Clear coincident with write ack discards that write
    do_write(20'h00100, 16'h1357, 1'b1);
    do_write(20'h00005, 16'h2468, 1'b0);
    do_read(20'h00005);
    do_read(20'h00006);

    // Reset during the write strobe aborts the access immediately
    @(posedge clk); #1;
    rec_addr = 20'h00300; rec_data = 16'h1234; rec_req = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_in_strobe", 64'(we_n), 64'(0));
    rst_n = 1'b0;
    #1;
    check("abort_we_n", 64'(we_n), 64'(1));
    check("abort_dq_oe", 64'(dq_oe), 64'(0));
    check("abort_ce_n", 64'(ce_n), 64'(1));
    rec_req = 1'b0;
    m_has = 1'b0; m_last = '0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    any_ack = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rec_ack) any_ack = 1'b1;
    end
    check("abort_no_ack", 64'(any_ack), 64'(0));
    check("abort_has_data", 64'(has_data), 64'(0));

    // Full contention right after reset
    contention(4);
    repeat (2) @(negedge clk);
    check("contention_last_addr", 64'(last_addr), 64'(m_last));

    // Randomized mix of writes, reads and clears
    do_clear();
    for (int i = 0; i < 40; i++) begin
      int r = int'($urandom_range(0, 9));
      logic [AW-1:0] a = 20'h00100 + AW'($urandom_range(0, 63));
      if (r == 0) do_clear();
      else if (r <= 4) do_write(a, 16'($urandom), 1'b0);
      else do_read(a);
    end
    do_read(20'hFFFFF);
    do_write(20'hFFFFF, 16'h7FFF, 1'b0);
    do_read(20'hFFFFF);

    repeat (5) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_sram_arbiter.md
# audio_sram_arbiter

Shares the single 16-bit external audio SRAM between the recorder write path and the DSP playback read path. It grants one requester at a time and sequences the SRAM control pins for each access. It also tracks the last recorded address, so playback past the end of the recording is flagged instead of returning stale memory. It sits between the recorder/player and the SRAM pins in the top level. The top level owns the tristate buffer and the stop decision.

## Interface
- ADDR_W, 20, SRAM word address width
- DATA_W, 16, sample/data width

- i_clk  input  1  bclk domain; all logic on rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_clear  input  1  single-cycle pulse; forgets recorded length (new recording session)
- i_rec_req  input  1  recorder write request, level, held until o_rec_ack
- i_rec_addr  input  ADDR_W  write address
- i_rec_data  input  DATA_W  write sample (signed, passed unchanged)
- o_rec_ack  output  1  one-cycle pulse: write committed
- i_play_req  input  1  player read request, level, held until o_play_ack
- i_play_addr  input  ADDR_W  read address
- o_play_data  output  DATA_W  read sample, valid from o_play_ack cycle until next read ack
- o_play_ack  output  1  one-cycle pulse: o_play_data updated
- o_play_eof  output  1  one-cycle pulse coincident with o_play_ack when read address is beyond recorded data
- o_sram_addr  output  ADDR_W  SRAM address pins
- o_sram_wdata  output  DATA_W  data driven onto DQ when o_sram_dq_oe=1
- i_sram_rdata  input  DATA_W  DQ pins as read
- o_sram_dq_oe  output  1  top-level tristate enable for DQ
- o_sram_ce_n / o_sram_we_n / o_sram_oe_n  output  1 each  SRAM strobes, active-low
- o_last_addr  output  ADDR_W  highest address written since clear
- o_has_data  output  1  at least one write since clear/reset

## Operation
- FSM states: IDLE, W_SETUP, W_STROBE, W_HOLD, R_STROBE, R_LATCH.
- IDLE: strobes high, dq_oe=0. Arbitration happens in this state.
  - Only rec_req → W_SETUP.
  - Only play_req → R_STROBE, or the EOF path.
  - Both requests → grant the side not served last (last_grant flag, reset = player, so recorder wins first tie). Neither side starves.
- Write: W_SETUP drives addr/wdata, ce_n=0, dq_oe=1, we_n=1. W_STROBE sets we_n=0. W_HOLD sets we_n=1, keeps data, pulses o_rec_ack, updates the pointer, then returns to IDLE.
- Pointer update on write ack: if !has_data or rec_addr > last_addr, last_addr ← rec_addr. has_data ← 1. Addresses are unsigned; there is no wrap, and address 2^ADDR_W−1 is valid.
- Read: R_STROBE drives addr, ce_n=0, oe_n=0, dq_oe=0. R_LATCH keeps oe_n=0, captures i_sram_rdata into o_play_data, pulses o_play_ack, then returns to IDLE.
- EOF path: a play_req granted in IDLE with !has_data or play_addr > last_addr issues no SRAM cycle. Next cycle: o_play_data ← 0, o_play_ack=1, o_play_eof=1, return to IDLE.
- Addresses and data are sampled at grant and held internally. Requester changes mid-transaction are ignored.
- A request still high in the cycle after its ack is a new request.
- i_clear: last_addr ← 0, has_data ← 0 on the next edge.
  - An in-flight transaction continues.
  - A write ack in the same cycle as i_clear: clear wins; that write is not counted.
  - A write ack after the clear counts normally.
- Reset (any time, including mid-strobe), applied immediately:
  - o_sram_ce_n/we_n/oe_n = 1; dq_oe = 0.
  - o_sram_addr, o_sram_wdata, o_play_data, o_last_addr = 0.
  - o_has_data, o_rec_ack, o_play_ack, o_play_eof = 0.
  - FSM = IDLE; last_grant = player.

## Timing
- All latencies are counted from the first rising edge that samples the request in IDLE (cycle N).
- Write: o_rec_ack high in cycle N+3. we_n low for exactly one cycle (N+2). Addr/data are stable N+1..N+3, a full cycle on each side of the strobe.
- Read: o_play_ack in cycle N+2. oe_n low N+1..N+2.
- EOF read: ack and eof in cycle N+1.
- After any ack the FSM is in IDLE for one cycle before the next grant.
  - Back-to-back write throughput: one per 4 cycles.
  - Back-to-back read throughput: one per 3 cycles.
  - Worst-case wait under full contention: 4 (one write) + 3 (own read) cycles. This is far below one LRCK sample period.
- dq_oe is never 1 while oe_n=0 (no bus contention). Assert this in the bench.

## Test plan
- Reset then idle: all strobes 1, dq_oe 0, o_has_data 0. A read of addr 0 returns data 0 with o_play_ack+o_play_eof at N+1.
- Single write: addr 0x00010, data 0x8001 → we_n low only at N+2, o_rec_ack at N+3. Then o_last_addr=0x00010, o_has_data=1.
- Read back 0x00010 with SRAM model → o_play_data=0x8001 at N+2, eof=0. Read 0x00011 → eof pulse, data 0.
- Simultaneous rec/play requests held for 20 cycles → grants strictly alternate, starting with recorder after reset. Check no dq_oe/oe_n overlap.
- i_clear in the same cycle as a write ack at 0x00100 → o_has_data=0 afterward. Next write to 0x00005 gives o_last_addr=0x00005.
- Assert i_rst_n low during W_STROBE → we_n=1 and dq_oe=0 within the same cycle. After release, no ack occurs for the aborted write.
